// File: rtl/o_pixel_writer.sv
// o_pixel_writer
//
// Output-side raster writer. Accepts processed pixels over a valid/ready
// stream and issues one memory write per pixel. Pixels are written in raster
// order starting at base_addr, so each pixel lands at
// base_addr + row*width + col. The writer tracks its own output column and
// row, and pulses frame_done once the last write of the frame has completed.
//
// Ports
//   clk        system clock, rising edge
//   clear      synchronous active-high reset
//   start      begin a frame (only looked at while idle)
//   width      frame columns, latched on an accepted start
//   height     frame rows, latched on an accepted start
//   base_addr  frame base address, latched on an accepted start
//   pix_valid  upstream pixel valid
//   pix_data   upstream pixel
//   pix_ready  writer accepts a pixel this cycle
//   mem_wr_en  write request, held until the memory takes it
//   mem_addr   write address
//   mem_wdata  write data
//   mem_busy   memory stall; a write completes when mem_wr_en=1 and mem_busy=0
//   col_out    column of the next pixel to accept
//   row_out    row of the next pixel to accept
//   busy       high whenever the writer is not idle
//   frame_done one-cycle pulse at end of frame
module o_pixel_writer #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              start,
    input  logic [12:0]       width,
    input  logic [12:0]       height,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_data,
    output logic              pix_ready,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_busy,
    output logic [12:0]       col_out,
    output logic [12:0]       row_out,
    output logic              busy,
    output logic              frame_done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [1:0]        state;
    logic [12:0]       frame_w;
    logic [12:0]       frame_h;
    logic [12:0]       col;
    logic [12:0]       row;
    logic [ADDR_W-1:0] next_addr;
    logic              last_accepted;

    logic              wr_done;
    logic              accept;
    logic              col_last;
    logic              row_last;

    // The output register can take a new pixel when it is empty, or when its
    // current write is leaving this very cycle; that is what sustains one
    // pixel per clock while the memory is not stalling.
    assign wr_done   = mem_wr_en & ~mem_busy;
    assign pix_ready = (state == S_WRITE) & ~last_accepted & (~mem_wr_en | ~mem_busy);
    assign accept    = pix_valid & pix_ready;
    assign col_last  = (col == frame_w - 13'd1);
    assign row_last  = (row == frame_h - 13'd1);

    assign col_out    = col;
    assign row_out    = row;
    assign busy       = (state != S_IDLE);
    assign frame_done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (clear) begin
            state         <= S_IDLE;
            frame_w       <= '0;
            frame_h       <= '0;
            col           <= '0;
            row           <= '0;
            next_addr     <= '0;
            last_accepted <= 1'b0;
            mem_wr_en     <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        frame_w       <= width;
                        frame_h       <= height;
                        col           <= '0;
                        row           <= '0;
                        next_addr     <= base_addr;
                        last_accepted <= 1'b0;
                        // An empty frame has nothing to write; finish at once.
                        if (width == 13'd0 || height == 13'd0) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_WRITE;
                        end
                    end
                end

                S_WRITE: begin
                    if (accept) begin
                        mem_wdata <= pix_data;
                        mem_addr  <= next_addr;
                        mem_wr_en <= 1'b1;
                        // Running address replaces base + row*width + col;
                        // it wraps naturally at 2^ADDR_W.
                        next_addr <= next_addr + ADDR_ONE;
                        if (col_last) begin
                            col <= '0;
                            row <= row + 13'd1;
                        end else begin
                            col <= col + 13'd1;
                        end
                        if (col_last && row_last) begin
                            last_accepted <= 1'b1;
                        end
                    end else if (wr_done) begin
                        mem_wr_en <= 1'b0;
                    end

                    // No accept can happen once the last pixel is in, so the
                    // completing write here is the final one of the frame.
                    if (last_accepted && wr_done) begin
                        state <= S_DONE;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_o_pixel_writer.sv
// tb_o_pixel_writer
//
// Directed bench for o_pixel_writer: a per-cycle vector table for a plain
// 3x2 frame, then hand-written sequences for stalls, address wrap,
// zero-dimension frames, mid-frame clear and start-during-frame.
`timescale 1ns/1ps
module tb_o_pixel_writer;

    logic        clk;
    logic        clear;
    logic        start;
    logic [12:0] width;
    logic [12:0] height;
    logic [23:0] base_addr;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        pix_ready;
    logic        mem_wr_en;
    logic [23:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_busy;
    logic [12:0] col_out;
    logic [12:0] row_out;
    logic        busy;
    logic        frame_done;

    int passed;
    int total;

    logic [23:0] wa[$];
    logic [7:0]  wdq[$];

    typedef struct {
        logic        start;
        logic [12:0] w;
        logic [12:0] h;
        logic [23:0] base;
        logic        pv;
        logic [7:0]  pd;
        logic        mb;
        logic        e_rdy;
        logic        e_wen;
        logic [23:0] e_addr;
        logic [7:0]  e_wd;
        logic [12:0] e_col;
        logic [12:0] e_row;
        logic        e_busy;
        logic        e_fd;
    } vec_t;

    vec_t tbl[10];

    o_pixel_writer #(.ADDR_W(24), .DATA_W(8)) dut (
        .clk        (clk),
        .clear      (clear),
        .start      (start),
        .width      (width),
        .height     (height),
        .base_addr  (base_addr),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_ready  (pix_ready),
        .mem_wr_en  (mem_wr_en),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_busy   (mem_busy),
        .col_out    (col_out),
        .row_out    (row_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " pix_ready"},  pix_ready,  0);
        chk({tag, " mem_wr_en"},  mem_wr_en,  0);
        chk({tag, " mem_addr"},   mem_addr,   0);
        chk({tag, " mem_wdata"},  mem_wdata,  0);
        chk({tag, " col_out"},    col_out,    0);
        chk({tag, " row_out"},    row_out,    0);
        chk({tag, " busy"},       busy,       0);
        chk({tag, " frame_done"}, frame_done, 0);
    endtask

    // Runs one frame with pix_valid held high. Pixel k carries 0x10+k.
    // Stalls the write to stall_addr for stall_n cycles; optionally pulses
    // start with other dimensions in the middle of the frame.
    task automatic run_frame(input string tag, input logic [12:0] w, input logic [12:0] h,
                             input logic [23:0] base, input logic [23:0] stall_addr,
                             input int stall_n, input logic [7:0] stall_data, input bit poke);
        int  k = 0;
        int  stalled = 0;
        int  hold_cnt = 0;
        int  cyc = 0;
        int  last_wr = -10;
        int  fd_cnt = 0;
        bit  done = 0;
        wa.delete();
        wdq.delete();
        @(negedge clk);
        start = 1'b1; width = w; height = h; base_addr = base;
        pix_valid = 1'b0; mem_busy = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (!done && cyc < 200) begin
            pix_valid = 1'b1;
            pix_data  = 8'(8'h10 + k);
            start     = poke && (cyc == 3);
            if (start) begin
                width = 13'd7; height = 13'd7; base_addr = 24'h005000;
            end
            mem_busy = mem_wr_en && (mem_addr == stall_addr) && (stalled < stall_n);
            #1;
            if (mem_busy) begin
                stalled++;
                chk({tag, " ready low in stall"}, pix_ready, 0);
            end
            if (stall_n > 0 && mem_wr_en && mem_addr == stall_addr) begin
                hold_cnt++;
                chk({tag, " stall data held"}, mem_wdata, stall_data);
            end
            chk($sformatf("%s col k=%0d", tag, k), col_out, k % int'(w));
            chk($sformatf("%s row k=%0d", tag, k), row_out, k / int'(w));
            if (mem_wr_en && !mem_busy) begin
                wa.push_back(mem_addr);
                wdq.push_back(mem_wdata);
                last_wr = cyc;
            end
            if (pix_ready && pix_valid) k++;
            if (frame_done) begin
                fd_cnt++;
                chk({tag, " frame_done cycle"}, cyc, last_wr + 1);
            end
            if (!busy && fd_cnt > 0) done = 1;
            cyc++;
            @(negedge clk);
            start = 1'b0;
        end
        pix_valid = 1'b0;
        mem_busy  = 1'b0;
        if (!done) chk({tag, " frame finished in budget"}, 0, 1);
        chk({tag, " frame_done pulses"}, fd_cnt, 1);
        chk({tag, " pixels accepted"}, k, int'(w) * int'(h));
        if (stall_n > 0) chk({tag, " stall hold cycles"}, hold_cnt, stall_n + 1);
    endtask

    task automatic chk_writes(input string tag, input logic [23:0] exp_a[6], input int n);
        chk({tag, " write count"}, wa.size(), n);
        for (int i = 0; i < n && i < wa.size(); i++) begin
            chk($sformatf("%s addr%0d", tag, i), wa[i], exp_a[i]);
            chk($sformatf("%s data%0d", tag, i), wdq[i], 8'(8'h10 + i));
        end
    endtask

    initial begin
        logic [23:0] ea[6];
        int wen_cycles;
        passed = 0; total = 0;
        clear = 1'b0; start = 1'b0; width = '0; height = '0; base_addr = '0;
        pix_valid = 1'b0; pix_data = '0; mem_busy = 1'b0;

        // start  w      h      base      pv    pd     mb    rdy   wen   addr      wd     col    row    busy  fd
        tbl[0] = '{1'b1, 13'd3, 13'd2, 24'h100, 1'b1, 8'hA0, 1'b0, 1'b0, 1'b0, 24'h000, 8'h00, 13'd0, 13'd0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 13'd0, 13'd0, 24'h000, 1'b1, 8'hA0, 1'b0, 1'b1, 1'b0, 24'h000, 8'h00, 13'd0, 13'd0, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 13'd0, 13'd0, 24'h000, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 24'h100, 8'hA0, 13'd1, 13'd0, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 13'd0, 13'd0, 24'h000, 1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 24'h101, 8'hA1, 13'd2, 13'd0, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 13'd0, 13'd0, 24'h000, 1'b1, 8'hA3, 1'b0, 1'b1, 1'b1, 24'h102, 8'hA2, 13'd0, 13'd1, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 13'd0, 13'd0, 24'h000, 1'b1, 8'hA4, 1'b0, 1'b1, 1'b1, 24'h103, 8'hA3, 13'd1, 13'd1, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 13'd0, 13'd0, 24'h000, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 24'h104, 8'hA4, 13'd2, 13'd1, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 13'd0, 13'd0, 24'h000, 1'b1, 8'hA6, 1'b0, 1'b0, 1'b1, 24'h105, 8'hA5, 13'd0, 13'd2, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 13'd0, 13'd0, 24'h000, 1'b1, 8'hA7, 1'b0, 1'b0, 1'b0, 24'h105, 8'hA5, 13'd0, 13'd2, 1'b1, 1'b1};
        tbl[9] = '{1'b0, 13'd0, 13'd0, 24'h000, 1'b1, 8'hA8, 1'b0, 1'b0, 1'b0, 24'h105, 8'hA5, 13'd0, 13'd2, 1'b0, 1'b0};

        // Reset
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        #1 chk_reset("reset");

        // Plain 3x2 frame, one vector per cycle
        wen_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = tbl[i].start; width = tbl[i].w; height = tbl[i].h; base_addr = tbl[i].base;
            pix_valid = tbl[i].pv; pix_data = tbl[i].pd; mem_busy = tbl[i].mb;
            #1;
            if (mem_wr_en) wen_cycles++;
            chk($sformatf("vec%0d pix_ready", i),  pix_ready,  tbl[i].e_rdy);
            chk($sformatf("vec%0d mem_wr_en", i),  mem_wr_en,  tbl[i].e_wen);
            chk($sformatf("vec%0d mem_addr", i),   mem_addr,   tbl[i].e_addr);
            chk($sformatf("vec%0d mem_wdata", i),  mem_wdata,  tbl[i].e_wd);
            chk($sformatf("vec%0d col_out", i),    col_out,    tbl[i].e_col);
            chk($sformatf("vec%0d row_out", i),    row_out,    tbl[i].e_row);
            chk($sformatf("vec%0d busy", i),       busy,       tbl[i].e_busy);
            chk($sformatf("vec%0d frame_done", i), frame_done, tbl[i].e_fd);
        end
        chk("vec wr_en cycles", wen_cycles, 6);
        @(negedge clk); pix_valid = 1'b0; start = 1'b0;

        // Same frame with the write to 0x102 stalled two cycles
        run_frame("stall", 13'd3, 13'd2, 24'h000100, 24'h000102, 2, 8'h12, 1'b0);
        ea = '{24'h100, 24'h101, 24'h102, 24'h103, 24'h104, 24'h105};
        chk_writes("stall", ea, 6);

        // 1x4 frame across the top of the address space
        run_frame("wrap", 13'd1, 13'd4, 24'hFFFFFE, 24'hABCDEF, 0, 8'h00, 1'b0);
        ea = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000, 24'h000001, 24'h0, 24'h0};
        chk_writes("wrap", ea, 4);

        // Zero-width frame
        @(negedge clk);
        start = 1'b1; width = 13'd0; height = 13'd5; base_addr = 24'h000700; pix_valid = 1'b1;
        #1 chk("zero idle busy", busy, 0);
        @(negedge clk); start = 1'b0;
        #1;
        chk("zero t+1 frame_done", frame_done, 1);
        chk("zero t+1 busy", busy, 1);
        chk("zero t+1 pix_ready", pix_ready, 0);
        chk("zero t+1 mem_wr_en", mem_wr_en, 0);
        @(negedge clk); #1;
        chk("zero t+2 frame_done", frame_done, 0);
        chk("zero t+2 busy", busy, 0);
        chk("zero t+2 pix_ready", pix_ready, 0);
        chk("zero t+2 mem_wr_en", mem_wr_en, 0);
        @(negedge clk); pix_valid = 1'b0;

        // Clear after two pixels with a write pending
        @(negedge clk);
        start = 1'b1; width = 13'd3; height = 13'd2; base_addr = 24'h000200;
        pix_valid = 1'b1; pix_data = 8'h30;
        @(negedge clk); start = 1'b0;
        #1 chk("clr first ready", pix_ready, 1);
        @(negedge clk); pix_data = 8'h31;
        #1 chk("clr first write addr", mem_addr, 24'h200);
        @(negedge clk); pix_data = 8'h32; mem_busy = 1'b1;
        #1;
        chk("clr pending wen", mem_wr_en, 1);
        chk("clr pending addr", mem_addr, 24'h201);
        chk("clr pending data", mem_wdata, 8'h31);
        chk("clr pending ready", pix_ready, 0);
        clear = 1'b1;
        @(negedge clk); clear = 1'b0; mem_busy = 1'b0;
        #1 chk_reset("after clear");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk($sformatf("post-clear wen c%0d", i), mem_wr_en, 0);
            chk($sformatf("post-clear rdy c%0d", i), pix_ready, 0);
        end
        @(negedge clk); pix_valid = 1'b0;
        run_frame("restart", 13'd3, 13'd2, 24'h000300, 24'hABCDEF, 0, 8'h00, 1'b0);
        ea = '{24'h300, 24'h301, 24'h302, 24'h303, 24'h304, 24'h305};
        chk_writes("restart", ea, 6);

        // start pulsed mid-frame with other dimensions
        run_frame("restart-ignored", 13'd3, 13'd2, 24'h000400, 24'hABCDEF, 0, 8'h00, 1'b1);
        ea = '{24'h400, 24'h401, 24'h402, 24'h403, 24'h404, 24'h405};
        chk_writes("restart-ignored", ea, 6);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
